// File: rtl/fetch_instruction.sv
// Fetch stage: owns the PC, issues reads to a variable-latency instruction memory and loads IF/ID.
// Latency: data accepted on the mem_done edge is visible on instr_out the following cycle.
// Backpressure: decode stall holds IF/ID; a read finishing under stall parks in a one-entry skid.
module fetch_instruction #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_en,
    input  logic [15:0] redirect_pc,
    input  logic        halt_dec,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_data,
    input  logic        mem_done,
    output logic [15:0] instr_out,
    output logic [15:0] pc_plus2_out,
    output logic        instr_valid,
    output logic        fetch_busy,
    output logic        halted
);
    localparam logic [15:0] NOP = 16'h0800;

    typedef enum logic [1:0] {S_REQ, S_HOLD, S_DRAIN, S_HALTED} state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] req_addr_q, req_addr_d;
    logic [15:0] skid_instr_q, skid_instr_d;
    logic [15:0] skid_pc2_q, skid_pc2_d;
    logic        discard_q, discard_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pc2_q, pc2_d;
    logic        valid_q, valid_d;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_addr_d   = req_addr_q;
        skid_instr_d = skid_instr_q;
        skid_pc2_d   = skid_pc2_q;
        discard_d    = discard_q;
        instr_d      = instr_q;
        pc2_d        = pc2_q;
        valid_d      = valid_q;

        unique case (state_q)
            S_REQ: begin
                if (redirect_en) begin
                    instr_d = NOP;
                    valid_d = 1'b0;
                    pc_d    = redirect_pc;
                    // A read in flight cannot be aborted; its data is dropped when it lands.
                    if (mem_done) begin
                        req_addr_d = redirect_pc;
                        discard_d  = 1'b0;
                    end else begin
                        discard_d  = 1'b1;
                    end
                end else if (halt_dec) begin
                    instr_d = NOP;
                    valid_d = 1'b0;
                    state_d = mem_done ? S_HALTED : S_DRAIN;
                end else if (mem_done) begin
                    if (discard_q) begin
                        req_addr_d = pc_q;
                        discard_d  = 1'b0;
                        if (!stall) begin
                            instr_d = NOP;
                            valid_d = 1'b0;
                        end
                    end else if (!stall) begin
                        instr_d    = mem_data;
                        pc2_d      = req_addr_q + 16'd2;
                        valid_d    = 1'b1;
                        req_addr_d = req_addr_q + 16'd2;
                        pc_d       = req_addr_q + 16'd4;
                    end else begin
                        skid_instr_d = mem_data;
                        skid_pc2_d   = req_addr_q + 16'd2;
                        pc_d         = req_addr_q + 16'd2;
                        state_d      = S_HOLD;
                    end
                end else if (!stall) begin
                    instr_d = NOP;
                    valid_d = 1'b0;
                end
            end
            S_HOLD: begin
                if (redirect_en) begin
                    instr_d    = NOP;
                    valid_d    = 1'b0;
                    pc_d       = redirect_pc;
                    req_addr_d = redirect_pc;
                    state_d    = S_REQ;
                end else if (halt_dec) begin
                    instr_d = NOP;
                    valid_d = 1'b0;
                    state_d = S_HALTED;
                end else if (!stall) begin
                    instr_d    = skid_instr_q;
                    pc2_d      = skid_pc2_q;
                    valid_d    = 1'b1;
                    req_addr_d = pc_q;
                    state_d    = S_REQ;
                end
            end
            S_DRAIN: begin
                instr_d = NOP;
                valid_d = 1'b0;
                if (mem_done) begin
                    state_d = S_HALTED;
                end
            end
            S_HALTED: begin
                instr_d = NOP;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            req_addr_q   <= RESET_PC;
            skid_instr_q <= 16'h0000;
            skid_pc2_q   <= 16'h0000;
            discard_q    <= 1'b0;
            instr_q      <= NOP;
            pc2_q        <= 16'h0000;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            skid_instr_q <= skid_instr_d;
            skid_pc2_q   <= skid_pc2_d;
            discard_q    <= discard_d;
            instr_q      <= instr_d;
            pc2_q        <= pc2_d;
            valid_q      <= valid_d;
        end
    end

    // Memory-side outputs depend only on registered state, never on stall/redirect.
    assign mem_rd       = (state_q == S_REQ) || (state_q == S_DRAIN);
    assign mem_addr     = req_addr_q;
    assign fetch_busy   = mem_rd & ~mem_done;
    assign halted       = (state_q == S_HALTED);
    assign instr_out    = instr_q;
    assign pc_plus2_out = pc2_q;
    assign instr_valid  = valid_q;

endmodule

// File: tb/tb_fetch_instruction.sv
// Bench for fetch_instruction: scoreboard of expected IF/ID contents against a latency-configurable memory.
module tb_fetch_instruction;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_en = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        halt_dec = 1'b0;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_done;
    logic [15:0] instr_out;
    logic [15:0] pc_plus2_out;
    logic        instr_valid;
    logic        fetch_busy;
    logic        halted;

    always #5 clk = ~clk;

    fetch_instruction #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect_en(redirect_en),
        .redirect_pc(redirect_pc), .halt_dec(halt_dec), .mem_rd(mem_rd),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_done(mem_done),
        .instr_out(instr_out), .pc_plus2_out(pc_plus2_out), .instr_valid(instr_valid),
        .fetch_busy(fetch_busy), .halted(halted)
    );

    // Memory: returns addr^A5A5, completing in the lat-th cycle of a request.
    int lat = 1;
    int cnt = 0;
    assign mem_data = mem_addr ^ 16'hA5A5;
    assign mem_done = !rst && mem_rd && (cnt == lat - 1);
    always @(posedge clk) begin
        if (rst || mem_done || !mem_rd) cnt <= 0;
        else cnt <= cnt + 1;
    end

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc2;
        int          gap;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          n_checks = 0;
    int          n_fail = 0;
    int          bub = 0;
    logic        pend = 1'b0;
    logic [15:0] pend_addr = 16'h0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [15:0] a, input int g);
        exp_t x;
        x.instr = a ^ 16'hA5A5;
        x.pc2   = a + 16'd2;
        x.gap   = g;
        q.push_back(x);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int l);
        cyc(1);
        rst = 1'b1; stall = 1'b0; redirect_en = 1'b0; halt_dec = 1'b0;
        redirect_pc = 16'h0000; lat = l;
        cyc(2);
        @(negedge clk);
        chk("rst_instr", instr_out, 16'h0800);
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_pc2", pc_plus2_out, 16'h0000);
        chk("rst_halted", halted, 1'b0);
        cyc(1);
        rst = 1'b0;
        @(negedge clk);
        chk("first_req", {mem_rd, mem_addr}, {1'b1, 16'h0000});
    endtask

    // Monitor: pops an expectation each time decode consumes a valid IF/ID entry.
    always @(negedge clk) begin
        if (rst) begin
            bub  = 0;
            pend = 1'b0;
        end else begin
            if (pend) chk("addr_stable", {mem_rd, mem_addr}, {1'b1, pend_addr});
            pend      = mem_rd && !mem_done;
            pend_addr = mem_addr;
            if (halted) chk("halted_no_rd", mem_rd, 1'b0);
            if (!instr_valid) begin
                chk("bubble_nop", instr_out, 16'h0800);
                bub++;
            end else if (!stall) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_instr: got %h/%h expected none at %0t",
                             instr_out, pc_plus2_out, $time);
                end else begin
                    e = q.pop_front();
                    chk("instr", instr_out, e.instr);
                    chk("pc_plus2", pc_plus2_out, e.pc2);
                    chk("bubble_gap", bub, e.gap);
                end
                bub = 0;
            end
        end
    end

    initial begin
        // Zero-wait memory: one instruction per cycle.
        do_reset(1);
        for (int a = 0; a < 6; a++) push(16'(2 * a), (a == 0) ? 1 : 0);
        cyc(7); stall = 1'b1;

        // Three-cycle reads: two bubbles between instructions.
        do_reset(3);
        push(16'h0000, 3); push(16'h0002, 2); push(16'h0004, 2);
        cyc(10); stall = 1'b1;

        // Redirect while the read of 0004 is outstanding.
        do_reset(3);
        push(16'h0000, 3); push(16'h0002, 2); push(16'h0100, 5); push(16'h0102, 2);
        cyc(7); redirect_en = 1'b1; redirect_pc = 16'h0100;
        cyc(1); redirect_en = 1'b0;
        cyc(1);
        @(negedge clk);
        chk("redir_addr", {mem_rd, mem_addr}, {1'b1, 16'h0100});
        cyc(7); stall = 1'b1;

        // Four-cycle stall while a read completes into the skid.
        do_reset(1);
        push(16'h0000, 1); push(16'h0002, 0); push(16'h0004, 0); push(16'h0006, 0);
        cyc(1); stall = 1'b1;
        cyc(1);
        @(negedge clk);
        chk("hold_no_rd", {mem_rd, fetch_busy}, 2'b00);
        cyc(3); stall = 1'b0;
        cyc(4); stall = 1'b1;

        // Redirect and halt together: redirect wins.
        do_reset(1);
        push(16'h0000, 1); push(16'h0040, 1); push(16'h0042, 0);
        cyc(1); redirect_en = 1'b1; halt_dec = 1'b1; redirect_pc = 16'h0040;
        cyc(1); redirect_en = 1'b0; halt_dec = 1'b0;
        @(negedge clk);
        chk("redir_over_halt", {halted, mem_addr}, {1'b0, 16'h0040});
        cyc(3); stall = 1'b1;
        @(negedge clk);
        chk("not_halted", halted, 1'b0);

        // Halt during an outstanding read drains it, then stops for good.
        do_reset(3);
        push(16'h0000, 3);
        cyc(4); halt_dec = 1'b1;
        cyc(1); halt_dec = 1'b0;
        @(negedge clk);
        chk("drain_rd", {mem_rd, halted, mem_addr}, {1'b1, 1'b0, 16'h0002});
        cyc(1); redirect_en = 1'b1; redirect_pc = 16'h0200; halt_dec = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("halted_state", {halted, mem_rd, instr_valid}, {1'b1, 1'b0, 1'b0});
            cyc(1);
        end
        redirect_en = 1'b0; halt_dec = 1'b0;

        // Redirect to FFFE: fetch wraps to 0000.
        do_reset(1);
        push(16'h0000, 1); push(16'hFFFE, 1); push(16'h0000, 0); push(16'h0002, 0);
        cyc(1); redirect_en = 1'b1; redirect_pc = 16'hFFFE;
        cyc(1); redirect_en = 1'b0;
        @(negedge clk);
        chk("wrap_addr0", mem_addr, 16'hFFFE);
        cyc(1);
        @(negedge clk);
        chk("wrap_addr1", mem_addr, 16'h0000);
        cyc(3); stall = 1'b1;
        cyc(2);

        chk("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
